// File: rtl/trigger_sequencer.sv
// trigger_sequencer: ordered multi-stage edge/pattern trigger with per-stage hit counts.
// Optional per-stage sample timeout is built when TRIGGER_SEQ_TIMEOUT_EN is defined.
module trigger_sequencer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned COUNT_WIDTH  = 8,
  parameter int unsigned CH_IDX_W     = $clog2(SAMPLE_WIDTH)
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic [SAMPLE_WIDTH-1:0]            sample,
  input  logic                               sampleValid,
  input  logic                               arm,
  input  logic                               abort,
  input  logic [SAMPLE_WIDTH-1:0]            activeChannels,
  input  logic [2:0]                         stagesUsed,
  input  logic [NUM_STAGES-1:0]              stageEdgeEn,
  input  logic [NUM_STAGES-1:0]              stageEdgeType,
  input  logic [NUM_STAGES*CH_IDX_W-1:0]     stageEdgeChannel,
  input  logic [NUM_STAGES-1:0]              stagePatternEn,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stagePattern,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stageDontCare,
  input  logic [NUM_STAGES*COUNT_WIDTH-1:0]  stageCount,
`ifdef TRIGGER_SEQ_TIMEOUT_EN
  input  logic [15:0]                        stageTimeout,
`endif
  output logic                               triggered,
  output logic                               done,
  output logic                               armed,
  output logic [2:0]                         currentStage,
  output logic                               transition
);

  localparam int unsigned STAGE_W = 3;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = 16;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [STAGE_W-1:0]      stage_q, stage_d;
  logic [COUNT_WIDTH-1:0]  hit_q, hit_d;
  logic [SAMPLE_WIDTH-1:0] prev_sample_q, prev_sample_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    triggered_q, triggered_d;
  logic                    done_q, done_d;
  logic                    armed_q;
  logic                    transition_q, transition_d;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
`endif

  logic                    sel_edge_en, sel_rise, sel_pat_en;
  logic [CH_IDX_W-1:0]     sel_ch;
  logic [SAMPLE_WIDTH-1:0] sel_pat, sel_dc;
  logic [COUNT_WIDTH-1:0]  sel_cnt;
  logic                    cur_bit, prev_bit;
  logic                    edge_term, pattern_term, stage_match;
  logic [COUNT_WIDTH-1:0]  target, hit_inc;
  logic                    advance, last_stage, start;

  // Pick the configuration of the stage currently being evaluated.
  always_comb begin
    sel_edge_en = 1'b0;
    sel_rise    = 1'b0;
    sel_pat_en  = 1'b0;
    sel_ch      = '0;
    sel_pat     = '0;
    sel_dc      = '0;
    sel_cnt     = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (stage_q == STAGE_W'(k)) begin
        sel_edge_en = stageEdgeEn[k];
        sel_rise    = stageEdgeType[k];
        sel_pat_en  = stagePatternEn[k];
        sel_ch      = stageEdgeChannel[k*CH_IDX_W +: CH_IDX_W];
        sel_pat     = stagePattern[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        sel_dc      = stageDontCare[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        sel_cnt     = stageCount[k*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  // Out-of-range edge channels read as constant 0 so the edge can never fire.
  always_comb begin
    cur_bit  = 1'b0;
    prev_bit = 1'b0;
    if (32'(sel_ch) < SAMPLE_WIDTH) begin
      cur_bit  = sample[sel_ch];
      prev_bit = prev_sample_q[sel_ch];
    end
  end

  assign edge_term    = ~sel_edge_en |
                        (prev_valid_q & (sel_rise ? (~prev_bit & cur_bit) : (prev_bit & ~cur_bit)));
  assign pattern_term = ~sel_pat_en | (&(~activeChannels | sel_dc | ~(sample ^ sel_pat)));
  assign stage_match  = edge_term & pattern_term;
  assign target       = (sel_cnt == '0) ? COUNT_WIDTH'(1) : sel_cnt;
  assign hit_inc      = hit_q + COUNT_WIDTH'(1);
  assign advance      = stage_match & (hit_inc == target);
  assign last_stage   = (stage_q == stagesUsed) || (stage_q == STAGE_W'(NUM_STAGES - 1));
  assign start        = arm & (state_q != S_ARMED);

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    hit_d         = hit_q;
    prev_sample_d = sampleValid ? sample : prev_sample_q;
    prev_valid_d  = prev_valid_q;
    triggered_d   = 1'b0;
    done_d        = done_q;
    transition_d  = sampleValid ? (prev_valid_q & (|(activeChannels & (sample ^ prev_sample_q))))
                                : transition_q;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif
    if (abort) begin
      state_d      = S_IDLE;
      stage_d      = '0;
      hit_d        = '0;
      prev_valid_d = 1'b0;
      done_d       = 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      to_cnt_d     = '0;
`endif
    end else if (start) begin
      state_d      = S_ARMED;
      stage_d      = '0;
      hit_d        = '0;
      prev_valid_d = 1'b0;
      done_d       = 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      to_cnt_d     = '0;
`endif
    end else if (sampleValid && state_q != S_IDLE) begin
      prev_valid_d = 1'b1;
      if (state_q == S_ARMED) begin
        if (stage_match) begin
          hit_d = hit_inc;
        end
        if (advance) begin
          hit_d = '0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (last_stage) begin
            state_d     = S_DONE;
            triggered_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
          end
        end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        else if (stage_q != '0) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (stageTimeout != '0 && to_cnt_d == stageTimeout) begin
            stage_d  = '0;
            hit_d    = '0;
            to_cnt_d = '0;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      stage_q       <= '0;
      hit_q         <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      triggered_q   <= 1'b0;
      done_q        <= 1'b0;
      armed_q       <= 1'b0;
      transition_q  <= 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      hit_q         <= hit_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      triggered_q   <= triggered_d;
      done_q        <= done_d;
      armed_q       <= (state_d == S_ARMED);
      transition_q  <= transition_d;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign triggered    = triggered_q;
  assign done         = done_q;
  assign armed        = armed_q;
  assign currentStage = stage_q;
  assign transition   = transition_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed scenarios plus randomized sequences
// compared cycle by cycle against a behavioural model.
module tb_trigger_sequencer;

  localparam int unsigned SW  = 16;
  localparam int unsigned NS  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned CIW = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [SW-1:0] sample_r = '0;
  logic sv_r = 1'b0, arm_r = 1'b0, abort_r = 1'b0;
  logic [SW-1:0] act_r = '0;
  logic [2:0] used_r = '0;
  logic [NS-1:0] een_r = '0, etype_r = '0, pen_r = '0;
  logic [NS*CIW-1:0] ech_r = '0;
  logic [NS*SW-1:0] pat_r = '0, dc_r = '0;
  logic [NS*CW-1:0] cnt_r = '0;
  logic [15:0] timeout_r = '0;
  logic triggered, done, armed, transition;
  logic [2:0] currentStage;

  always #5 clk = ~clk;

  trigger_sequencer #(.SAMPLE_WIDTH(SW), .NUM_STAGES(NS), .COUNT_WIDTH(CW), .CH_IDX_W(CIW)) dut (
    .clk(clk), .resetN(resetN), .sample(sample_r), .sampleValid(sv_r), .arm(arm_r), .abort(abort_r),
    .activeChannels(act_r), .stagesUsed(used_r), .stageEdgeEn(een_r), .stageEdgeType(etype_r),
    .stageEdgeChannel(ech_r), .stagePatternEn(pen_r), .stagePattern(pat_r), .stageDontCare(dc_r),
    .stageCount(cnt_r),
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    .stageTimeout(timeout_r),
`endif
    .triggered(triggered), .done(done), .armed(armed), .currentStage(currentStage),
    .transition(transition)
  );

  // Stage configuration as plain arrays; packed onto the DUT ports by apply_cfg.
  bit cfg_een[NS], cfg_rise[NS], cfg_pen[NS];
  int cfg_ch[NS], cfg_cnt[NS];
  logic [SW-1:0] cfg_pat[NS], cfg_dc[NS];
  logic [SW-1:0] cfg_act;
  int cfg_used, cfg_timeout;

  int m_state, m_stage, m_hits, m_to;
  logic [SW-1:0] m_prev;
  bit m_pv, m_trans, m_trig, m_done;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < int'(NS); k++) begin
      een_r[k]   = cfg_een[k];
      etype_r[k] = cfg_rise[k];
      pen_r[k]   = cfg_pen[k];
      ech_r[k*CIW +: CIW] = CIW'(cfg_ch[k]);
      pat_r[k*SW +: SW]   = cfg_pat[k];
      dc_r[k*SW +: SW]    = cfg_dc[k];
      cnt_r[k*CW +: CW]   = CW'(cfg_cnt[k]);
    end
    act_r     = cfg_act;
    used_r    = 3'(cfg_used);
    timeout_r = 16'(cfg_timeout);
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < int'(NS); k++) begin
      cfg_een[k] = 0; cfg_rise[k] = 0; cfg_pen[k] = 0; cfg_ch[k] = 0; cfg_cnt[k] = 1;
      cfg_pat[k] = '0; cfg_dc[k] = '0;
    end
    cfg_act = '1; cfg_used = 0; cfg_timeout = 0;
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_stage = 0; m_hits = 0; m_to = 0;
    m_prev = '0; m_pv = 0; m_trans = 0; m_trig = 0; m_done = 0;
  endtask

  function automatic bit edge_ok(input int k, input logic [SW-1:0] s);
    bit p, c;
    if (!cfg_een[k]) return 1'b1;
    if (cfg_ch[k] >= int'(SW)) return 1'b0;
    p = m_prev[cfg_ch[k]];
    c = s[cfg_ch[k]];
    if (!m_pv) return 1'b0;
    return cfg_rise[k] ? (!p && c) : (p && !c);
  endfunction

  function automatic bit pattern_ok(input int k, input logic [SW-1:0] s);
    if (!cfg_pen[k]) return 1'b1;
    for (int i = 0; i < int'(SW); i++)
      if (cfg_act[i] && !cfg_dc[k][i] && s[i] != cfg_pat[k][i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of the behavioural model, using the inputs presented for this edge.
  task automatic model_step();
    logic [SW-1:0] s;
    bit new_trans, matched;
    int need;
    s = sample_r;
    m_trig = 0;
    new_trans = sv_r ? (m_pv && ((cfg_act & (s ^ m_prev)) != '0)) : m_trans;
    if (abort_r) begin
      m_state = M_IDLE; m_stage = 0; m_hits = 0; m_pv = 0; m_done = 0; m_to = 0;
    end else if (arm_r && m_state != M_ARMED) begin
      m_state = M_ARMED; m_stage = 0; m_hits = 0; m_pv = 0; m_done = 0; m_to = 0;
    end else if (sv_r && m_state == M_ARMED) begin
      matched = edge_ok(m_stage, s) && pattern_ok(m_stage, s);
      m_pv = 1;
      need = (cfg_cnt[m_stage] == 0) ? 1 : cfg_cnt[m_stage];
      if (matched) m_hits++;
      if (matched && m_hits == need) begin
        m_hits = 0; m_to = 0;
        if (m_stage == cfg_used) begin
          m_state = M_DONE; m_trig = 1; m_done = 1;
        end else begin
          m_stage++;
        end
      end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      else if (m_stage > 0) begin
        m_to++;
        if (cfg_timeout != 0 && m_to == cfg_timeout) begin
          m_stage = 0; m_hits = 0; m_to = 0;
        end
      end
`endif
    end else if (sv_r && m_state == M_DONE) begin
      m_pv = 1;
    end
    if (sv_r) m_prev = s;
    m_trans = new_trans;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".triggered"},    32'(triggered),    32'(m_trig));
    check({tag, ".done"},         32'(done),         32'(m_done));
    check({tag, ".armed"},        32'(armed),        32'(m_state == M_ARMED));
    check({tag, ".currentStage"}, 32'(currentStage), 32'(m_stage));
    check({tag, ".transition"},   32'(transition),   32'(m_trans));
  endtask

  task automatic step(input logic sv, input logic [SW-1:0] s, input logic a, input logic ab,
                      input string tag);
    sv_r = sv; sample_r = s; arm_r = a; abort_r = ab;
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  // Async reset between clock edges; outputs must clear without waiting for a clock.
  task automatic reset_pulse(input string tag);
    #2 resetN = 1'b0;
    #1;
    check({tag, ".triggered"},    32'(triggered),    32'd0);
    check({tag, ".done"},         32'(done),         32'd0);
    check({tag, ".armed"},        32'(armed),        32'd0);
    check({tag, ".currentStage"}, 32'(currentStage), 32'd0);
    check({tag, ".transition"},   32'(transition),   32'd0);
    model_reset();
    #1 resetN = 1'b1;
  endtask

  initial begin
    logic [SW-1:0] s, keep;
    int st;
    clear_cfg();
    apply_cfg();
    model_reset();

    #3;
    check("reset.triggered", 32'(triggered), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.armed", 32'(armed), 32'd0);
    check("reset.stage", 32'(currentStage), 32'd0);
    check("reset.transition", 32'(transition), 32'd0);
    #4 resetN = 1'b1;

    // Single stage: rising edge on ch3.
    cfg_een[0] = 1; cfg_rise[0] = 1; cfg_ch[0] = 3; cfg_cnt[0] = 1; cfg_used = 0;
    apply_cfg();
    step(1, 16'h0000, 0, 0, "s1.pre");
    step(0, 16'h0000, 1, 0, "s1.arm");
    check("s1.armed", 32'(armed), 32'd1);
    step(1, 16'h0000, 0, 0, "s1.low");
    step(1, 16'h0008, 0, 0, "s1.rise");
    check("s1.trig_pulse", 32'(triggered), 32'd1);
    check("s1.done_set", 32'(done), 32'd1);
    step(0, 16'h0008, 0, 0, "s1.after");
    check("s1.trig_clear", 32'(triggered), 32'd0);
    check("s1.done_held", 32'(done), 32'd1);

    // First valid sample after arm cannot form an edge.
    step(1, 16'h0000, 0, 0, "pv.low");
    step(0, 16'h0000, 1, 0, "pv.arm");
    step(1, 16'h0008, 0, 0, "pv.first");
    check("pv.no_trig", 32'(triggered), 32'd0);
    check("pv.still_armed", 32'(armed), 32'd1);
    step(1, 16'h0000, 0, 0, "pv.fall");
    step(1, 16'h0008, 0, 0, "pv.rise");
    check("pv.trig", 32'(triggered), 32'd1);

    // Two stages: pattern 0xA5 x3 (non-consecutive), then ch0 falling.
    clear_cfg();
    cfg_pen[0] = 1; cfg_pat[0] = 16'h00A5; cfg_cnt[0] = 3;
    cfg_een[1] = 1; cfg_rise[1] = 0; cfg_ch[1] = 0; cfg_cnt[1] = 1;
    cfg_act = 16'h00FF; cfg_used = 1;
    apply_cfg();
    step(0, 16'h0000, 1, 0, "s2.arm");
    step(1, 16'h00A5, 0, 0, "s2.hit1");
    step(1, 16'h0000, 0, 0, "s2.miss1");
    step(1, 16'hFFA5, 0, 0, "s2.hit2");
    check("s2.stage0", 32'(currentStage), 32'd0);
    step(1, 16'h0011, 0, 0, "s2.miss2");
    step(1, 16'h00A5, 0, 0, "s2.hit3");
    check("s2.stage1", 32'(currentStage), 32'd1);
    check("s2.no_trig_yet", 32'(triggered), 32'd0);
    step(1, 16'h00A4, 0, 0, "s2.fall");
    check("s2.trig", 32'(triggered), 32'd1);
    check("s2.done", 32'(done), 32'd1);

    // abort beats arm while armed; then async reset at stage 1.
    step(0, 16'h0000, 1, 0, "ab.arm");
    for (int i = 0; i < 3; i++) step(1, 16'h00A5, 0, 0, "ab.hit");
    check("ab.stage1", 32'(currentStage), 32'd1);
    step(0, 16'h0000, 1, 1, "ab.both");
    check("ab.armed", 32'(armed), 32'd0);
    check("ab.stage", 32'(currentStage), 32'd0);
    step(0, 16'h0000, 1, 0, "rs.arm");
    for (int i = 0; i < 3; i++) step(1, 16'h00A5, 0, 0, "rs.hit");
    check("rs.stage1", 32'(currentStage), 32'd1);
    reset_pulse("rs.async");

    // transition honours activeChannels and holds between valid samples.
    clear_cfg();
    cfg_een[0] = 1; cfg_rise[0] = 1; cfg_ch[0] = 15; cfg_act = 16'h0001;
    apply_cfg();
    step(0, 16'h0000, 1, 0, "tr.arm");
    step(1, 16'h0000, 0, 0, "tr.base");
    step(1, 16'h0010, 0, 0, "tr.bit4");
    check("tr.inactive", 32'(transition), 32'd0);
    step(1, 16'h0011, 0, 0, "tr.bit0");
    check("tr.active", 32'(transition), 32'd1);
    step(0, 16'h0000, 0, 0, "tr.hold");
    check("tr.held", 32'(transition), 32'd1);
    step(1, 16'h0011, 0, 0, "tr.same");
    check("tr.same", 32'(transition), 32'd0);
    step(0, 16'h0000, 0, 1, "tr.abort");

`ifdef TRIGGER_SEQ_TIMEOUT_EN
    // Timeout: five non-advancing samples at stage 1 restart at stage 0.
    clear_cfg();
    cfg_act = 16'h0003; cfg_used = 1; cfg_timeout = 5;
    cfg_pen[0] = 1; cfg_pat[0] = 16'h0001; cfg_dc[0] = 16'h0002;
    cfg_pen[1] = 1; cfg_pat[1] = 16'h0002; cfg_dc[1] = 16'h0001;
    apply_cfg();
    step(0, 16'h0000, 1, 0, "to.arm");
    step(1, 16'h0001, 0, 0, "to.adv");
    check("to.stage1", 32'(currentStage), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 16'h0000, 0, 0, "to.wait");
    check("to.still1", 32'(currentStage), 32'd1);
    step(1, 16'h0000, 0, 0, "to.expire");
    check("to.back0", 32'(currentStage), 32'd0);
    step(0, 16'h0000, 0, 1, "to.abort");
`endif

    // Randomized sequences against the model.
    for (int r = 0; r < 10; r++) begin
      step(1, 16'($urandom), 0, 1, "rnd.abort");
      for (int k = 0; k < int'(NS); k++) begin
        cfg_een[k]  = bit'($urandom_range(0, 1));
        cfg_rise[k] = bit'($urandom_range(0, 1));
        cfg_pen[k]  = bit'($urandom_range(0, 1));
        cfg_ch[k]   = $urandom_range(0, SW - 1);
        cfg_cnt[k]  = $urandom_range(0, 3);
        cfg_pat[k]  = 16'($urandom);
        cfg_dc[k]   = 16'($urandom) | 16'($urandom);
      end
      cfg_act = 16'($urandom) | 16'h0001;
      cfg_used = $urandom_range(0, NS - 1);
      cfg_timeout = $urandom_range(0, 1) ? 0 : $urandom_range(2, 6);
      apply_cfg();
      step(0, 16'($urandom), 1, 0, "rnd.arm");
      for (int c = 0; c < 120; c++) begin
        s = 16'($urandom);
        st = m_stage;
        if ($urandom_range(0, 1) == 1) begin
          keep = cfg_act & ~cfg_dc[st];
          s = (cfg_pat[st] & keep) | (s & ~keep);
        end
        step(bit'($urandom_range(0, 3) != 0), s, bit'($urandom_range(0, 29) == 0),
             bit'($urandom_range(0, 79) == 0), "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Multi-stage, parametrised trigger engine for the logic-capture path. It evaluates up to NUM_STAGES edge/pattern conditions in strict order on the sample stream and requires a programmable occurrence count at each stage. It keeps its own previous-sample register and emits a registered trigger pulse and a transition flag to the capture controller.

## Interface
- SAMPLE_WIDTH, 16, number of channels.
- NUM_STAGES, 4, number of sequence stages (1..8).
- COUNT_WIDTH, 8, width of each stage's occurrence count.
- CH_IDX_W, $clog2(SAMPLE_WIDTH), width of an edge channel index.
- clk, input, 1, sample clock.
- resetN, input, 1, asynchronous active-low reset.
- sample, input, SAMPLE_WIDTH, current sample, qualified by sampleValid.
- sampleValid, input, 1, sample is new this cycle.
- arm, input, 1, one-cycle pulse: start sequence at stage 0.
- abort, input, 1, one-cycle pulse: return to IDLE.
- activeChannels, input, SAMPLE_WIDTH, channels being measured.
- stagesUsed, input, 3, last stage index in use (0..NUM_STAGES-1).
- stageEdgeEn, input, NUM_STAGES, per-stage edge condition enable.
- stageEdgeType, input, NUM_STAGES, 1 = rising, 0 = falling.
- stageEdgeChannel, input, NUM_STAGES*CH_IDX_W, per-stage edge channel (stage k at [k*CH_IDX_W +: CH_IDX_W]).
- stagePatternEn, input, NUM_STAGES, per-stage pattern condition enable.
- stagePattern, input, NUM_STAGES*SAMPLE_WIDTH, per-stage desired values.
- stageDontCare, input, NUM_STAGES*SAMPLE_WIDTH, per-stage ignored channels.
- stageCount, input, NUM_STAGES*COUNT_WIDTH, hits required per stage (0 is treated as 1).
- triggered, output, 1, one-cycle pulse on sequence completion.
- done, output, 1, held high from the trigger until the next arm, abort or reset.
- armed, output, 1, state is ARMED.
- currentStage, output, 3, stage being evaluated.
- transition, output, 1, registered: an active channel changed on the last valid sample.

## Operation
- States:
  - IDLE: arm goes to ARMED with stage 0, hit count 0 and prevValid 0.
  - ARMED: advances through the stages.
  - DONE: arm goes to ARMED (re-arm).
  - abort in any state goes to IDLE. abort beats arm when both are asserted.
- Stage condition for stage k, evaluated only on a cycle with sampleValid:
  - Edge term: if stageEdgeEn[k] is 0, the term is 1. Otherwise it requires prevValid and the chosen bit going prev→cur as 0→1 (rising) or 1→0 (falling).
  - Pattern term: if stagePatternEn[k] is 0, the term is 1. Otherwise it is AND over (~activeChannels | dontCare | ~(sample ^ pattern)).
  - Both terms enabled-off means the stage matches on every valid sample.
- Counting:
  - Each match increments the hit count.
  - When the count reaches max(stageCount[k], 1), the count clears and currentStage increments.
  - When the completing stage equals stagesUsed, the block pulses triggered, sets done and enters DONE.
  - Hit counts do not reset on a non-matching sample; hits accumulate, they need not be consecutive.
- An edge channel index ≥ SAMPLE_WIDTH is treated as constant 0, so the edge never fires.
- prevSample loads sample on every sampleValid in all states. prevValid sets on the first valid sample after arm.
- transition = |(activeChannels & (sample ^ prevSample)), registered on sampleValid, gated by prevValid. It holds its value between valid samples.

## Timing
- All outputs are registered. Reset values: triggered 0, done 0, armed 0, currentStage 0, transition 0. prevSample and hit count also reset to 0.
- Latency: the valid sample completing the last stage produces triggered=1 and done=1 on the next clock edge.
- One stage advance at most per valid sample. A sample completing stage k is not re-evaluated against stage k+1.
- Configuration inputs must be stable while armed. Changes while armed are undefined.
- Asynchronous reset mid-sequence returns immediately to IDLE with all outputs 0.

## Configuration
- TRIGGER_SEQ_TIMEOUT_EN defined:
  - Adds input stageTimeout (16 bits).
  - While in ARMED with currentStage > 0, a counter counts valid samples since the last stage advance.
  - Reaching stageTimeout (nonzero) restarts the sequence at stage 0 with the hit count cleared.
  - stageTimeout = 0 disables the timeout.
- Undefined: no port, no counter; the sequence waits indefinitely.

## Test plan
- Single stage, rising edge on channel 3, count 1, pattern off; sample ch3 goes 0→1 → triggered pulses one cycle after that sample, done stays 1.
- Two stages: stage 0 pattern 0x00A5 with activeChannels 0x00FF, count 3 (non-consecutive hits); stage 1 falling edge on channel 0 → triggered only after 3 pattern hits followed by a ch0 fall; currentStage reads 0, then 1, then done.
- First valid sample after arm has ch3=1 with prevSample ch3=0 from before arm → no edge match (prevValid=0).
- abort and arm asserted in the same cycle while armed → IDLE, armed=0; resetN pulsed low at stage 1 → all outputs 0 immediately.
- transition: activeChannels 0x0001, sample toggles bit 4 only → transition=0; toggles bit 0 → transition=1 on the next clock.
- With TRIGGER_SEQ_TIMEOUT_EN, stageTimeout=5: advance to stage 1, then 5 non-matching samples → currentStage returns to 0.
